// File: rtl/rf_pkg.sv
// Shared definitions for the register file with block-transfer sequencer:
// sequencer state encoding and default geometry of the register file.
package rf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } blk_state_e;

  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 4;
  localparam int RF_PC_IDX  = 15;
  localparam int RF_PC_STEP = 4;

endpackage

// File: rtl/rf_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// set bit of vec and a flag telling whether any bit is set at all.
module rf_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_blk_xfer.sv
// CPU register file with three combinational read ports, one write port, a
// PC register with load/auto-increment, and an LDM/STM block-transfer sequencer
// that walks a register-list bitmask lowest index first.
// Optional feature: define RF_WRITE_BYPASS_EN to forward wr_data to the read
// ports and blk_rdata in the same cycle as the write.
module reg_file_blk_xfer
  import rf_pkg::*;
#(
  parameter  int DATA_W  = RF_DATA_W,
  parameter  int ADDR_W  = RF_ADDR_W,
  parameter  int PC_IDX  = RF_PC_IDX,
  parameter  int PC_STEP = RF_PC_STEP,
  localparam int NREGS   = 2 ** ADDR_W
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rn_addr,
  output logic [DATA_W-1:0] rn_data,
  input  logic [ADDR_W-1:0] rm_addr,
  output logic [DATA_W-1:0] rm_data,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] pc_out,
  input  logic              blk_start,
  input  logic              blk_load,
  input  logic [NREGS-1:0]  blk_list,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [ADDR_W-1:0] blk_idx,
  output logic [DATA_W-1:0] blk_rdata,
  input  logic [DATA_W-1:0] blk_wdata,
  output logic              blk_busy,
  output logic              blk_done
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  blk_state_e        state_q, state_d;
  logic [NREGS-1:0]  list_q, list_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [NREGS-1:0]  list_rem;
  logic [NREGS-1:0]  enc_in;
  logic [ADDR_W-1:0] enc_idx;
  logic              enc_any;
  logic              beat;
  logic              ldm_wr;

  // In IDLE the encoder looks at the incoming list; during a transfer it looks
  // at what remains once the current beat's bit is cleared.
  assign list_rem = list_q & ~(NREGS'(1) << idx_q);
  assign enc_in   = (state_q == ST_IDLE) ? blk_list : list_rem;

  rf_prio_enc #(.N(NREGS), .W(ADDR_W)) u_prio_enc (
    .vec (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign beat   = (state_q == ST_XFER) && blk_ready;
  assign ldm_wr = beat && load_q;

  // Read helper; the forwarding path is deliberately fed by wr_en only, never by the LDM beat
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
`ifdef RF_WRITE_BYPASS_EN
    if (wr_en && (wr_addr == a)) return wr_data;
`endif
    return regs_q[a];
  endfunction

  assign rn_data   = read_port(rn_addr);
  assign rm_data   = read_port(rm_addr);
  assign rs_data   = read_port(rs_addr);
  assign blk_rdata = read_port(idx_q);
  assign pc_out    = regs_q[PC_IDX];

  assign blk_valid = (state_q == ST_XFER);
  assign blk_done  = (state_q == ST_DONE);
  assign blk_busy  = (state_q != ST_IDLE);
  assign blk_idx   = idx_q;

  // Per-register next value; later assignments override earlier ones, giving LDM > pc_load > pc_inc > wr_en
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_addr == ADDR_W'(i))) regs_d[i] = wr_data;
      if (i == PC_IDX) begin
        if (pc_inc)  regs_d[i] = regs_q[i] + DATA_W'(PC_STEP);
        if (pc_load) regs_d[i] = pc_in;
      end
      if (ldm_wr && (idx_q == ADDR_W'(i))) regs_d[i] = blk_wdata;
    end
  end

  // Sequencer next state: latch list/mode on start, advance one set bit per accepted beat
  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    load_d  = load_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (blk_start) begin
          if (enc_any) begin
            state_d = ST_XFER;
            list_d  = blk_list;
            load_d  = blk_load;
            idx_d   = enc_idx;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_XFER: begin
        if (blk_ready) begin
          list_d = list_rem;
          if (enc_any) idx_d = enc_idx;
          else         state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything and aborts any transfer in flight
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      state_q <= ST_IDLE;
      list_q  <= '0;
      load_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      state_q <= state_d;
      list_q  <= list_d;
      load_q  <= load_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_reg_file_blk_xfer.sv
// Directed self-checking bench for reg_file_blk_xfer (default geometry:
// 16 x 32-bit, PC at R15, step 4). Honours RF_WRITE_BYPASS_EN for the
// same-cycle write-through expectation.
module tb_reg_file_blk_xfer;

  logic        Clk;
  logic        RESET;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rn_addr, rm_addr, rs_addr;
  logic [31:0] rn_data, rm_data, rs_data;
  logic        pc_load, pc_inc;
  logic [31:0] pc_in, pc_out;
  logic        blk_start, blk_load;
  logic [15:0] blk_list;
  logic        blk_valid, blk_ready;
  logic [3:0]  blk_idx;
  logic [31:0] blk_rdata, blk_wdata;
  logic        blk_busy, blk_done;

  int total = 0;
  int bad   = 0;

  reg_file_blk_xfer dut (
    .Clk       (Clk),
    .RESET     (RESET),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rn_addr   (rn_addr),
    .rn_data   (rn_data),
    .rm_addr   (rm_addr),
    .rm_data   (rm_data),
    .rs_addr   (rs_addr),
    .rs_data   (rs_data),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .pc_in     (pc_in),
    .pc_out    (pc_out),
    .blk_start (blk_start),
    .blk_load  (blk_load),
    .blk_list  (blk_list),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_idx   (blk_idx),
    .blk_rdata (blk_rdata),
    .blk_wdata (blk_wdata),
    .blk_busy  (blk_busy),
    .blk_done  (blk_done)
  );

  // Free-running clock, 10 time units per period
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle 1 unit past it before anything is checked or driven
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
  endtask

  // One comparison: counts it, and reports tag/observed/expected when it fails
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    RESET = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rn_addr = 0; rm_addr = 0; rs_addr = 0;
    pc_load = 0; pc_inc = 0; pc_in = 0;
    blk_start = 0; blk_load = 0; blk_list = 0; blk_ready = 0; blk_wdata = 0;
    applyStimulus();
    applyStimulus();
    RESET = 1'b0;

    // Reset state
    checkOutput("rst_pc",    pc_out,    32'h0);
    checkOutput("rst_rn",    rn_data,   32'h0);
    checkOutput("rst_busy",  {31'b0, blk_busy},  32'h0);
    checkOutput("rst_valid", {31'b0, blk_valid}, 32'h0);
    checkOutput("rst_done",  {31'b0, blk_done},  32'h0);
    checkOutput("rst_idx",   {28'b0, blk_idx},   32'h0);

    // Plain write to R3, visible after the edge (same cycle only with forwarding)
    wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF;
    rn_addr = 3; rm_addr = 3; rs_addr = 0;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    checkOutput("wr_same_cycle", rn_data, 32'hDEADBEEF);
`else
    checkOutput("wr_same_cycle", rn_data, 32'h0);
`endif
    applyStimulus();
    wr_en = 0;
    #1;
    checkOutput("wr_rn", rn_data, 32'hDEADBEEF);
    checkOutput("wr_rm", rm_data, 32'hDEADBEEF);
    checkOutput("wr_rs_other", rs_data, 32'h0);

    // PC load, wrap on increment, load beats inc, inc alone, load beats wr_en
    pc_load = 1; pc_in = 32'hFFFFFFFC; rn_addr = 15;
    applyStimulus();
    pc_load = 0;
    checkOutput("pc_load", pc_out, 32'hFFFFFFFC);
    checkOutput("pc_via_rn", rn_data, 32'hFFFFFFFC);
    pc_inc = 1;
    applyStimulus();
    pc_inc = 0;
    checkOutput("pc_wrap", pc_out, 32'h0);
    pc_load = 1; pc_inc = 1; pc_in = 32'h100;
    applyStimulus();
    pc_load = 0;
    checkOutput("pc_load_over_inc", pc_out, 32'h100);
    applyStimulus();
    pc_inc = 0;
    checkOutput("pc_inc", pc_out, 32'h104);
    pc_load = 1; pc_in = 32'h200; wr_en = 1; wr_addr = 15; wr_data = 32'h5;
    applyStimulus();
    pc_load = 0; wr_en = 0;
    checkOutput("pc_load_over_wr", pc_out, 32'h200);

    // STM over list 0x8009 with ready held high: R0, R3, R15 on consecutive cycles
    wr_en = 1; wr_addr = 0; wr_data = 32'hA0;
    applyStimulus();
    wr_en = 0;
    blk_start = 1; blk_load = 0; blk_list = 16'h8009; blk_ready = 1;
    applyStimulus();
    blk_start = 0; blk_list = 0;
    checkOutput("stm_valid0", {31'b0, blk_valid}, 32'h1);
    checkOutput("stm_busy0",  {31'b0, blk_busy},  32'h1);
    checkOutput("stm_idx0",   {28'b0, blk_idx},   32'h0);
    checkOutput("stm_data0",  blk_rdata,          32'hA0);
    applyStimulus();
    checkOutput("stm_idx1",   {28'b0, blk_idx},   32'h3);
    checkOutput("stm_data1",  blk_rdata,          32'hDEADBEEF);
    applyStimulus();
    checkOutput("stm_idx2",   {28'b0, blk_idx},   32'hF);
    checkOutput("stm_data2",  blk_rdata,          32'h200);
    checkOutput("stm_nodone", {31'b0, blk_done},  32'h0);
    applyStimulus();
    blk_ready = 0;
    checkOutput("stm_done",   {31'b0, blk_done},  32'h1);
    checkOutput("stm_valid_done", {31'b0, blk_valid}, 32'h0);
    applyStimulus();
    checkOutput("stm_done_pulse", {31'b0, blk_done}, 32'h0);
    checkOutput("stm_idle",   {31'b0, blk_busy},  32'h0);

    // LDM over list 0x0006 with stalls; final beat races a wr_en to R2
    rn_addr = 1; rm_addr = 2;
    blk_start = 1; blk_load = 1; blk_list = 16'h0006; blk_ready = 0;
    applyStimulus();
    blk_start = 0; blk_list = 0; blk_wdata = 32'h11;
    checkOutput("ldm_idx_a", {28'b0, blk_idx}, 32'h1);
    applyStimulus();
    checkOutput("ldm_stall_idx", {28'b0, blk_idx}, 32'h1);
    checkOutput("ldm_stall_r1",  rn_data,          32'h0);
    blk_ready = 1;
    applyStimulus();
    blk_ready = 0; blk_wdata = 32'h22;
    checkOutput("ldm_r1",    rn_data,          32'h11);
    checkOutput("ldm_idx_b", {28'b0, blk_idx}, 32'h2);
    applyStimulus();
    checkOutput("ldm_stall_idx2", {28'b0, blk_idx}, 32'h2);
    checkOutput("ldm_stall_r2",   rm_data,          32'h0);
    blk_ready = 1; wr_en = 1; wr_addr = 2; wr_data = 32'h99;
    applyStimulus();
    blk_ready = 0; wr_en = 0;
    checkOutput("ldm_r2_wins", rm_data, 32'h22);
    checkOutput("ldm_done",    {31'b0, blk_done}, 32'h1);
    applyStimulus();
    checkOutput("ldm_idle",    {31'b0, blk_busy}, 32'h0);

    // Empty list goes straight to DONE
    blk_start = 1; blk_list = 16'h0;
    applyStimulus();
    blk_start = 0;
    checkOutput("empty_done",  {31'b0, blk_done},  32'h1);
    checkOutput("empty_valid", {31'b0, blk_valid}, 32'h0);
    applyStimulus();
    checkOutput("empty_pulse", {31'b0, blk_done},  32'h0);

    // Reset in the middle of a stalled transfer aborts it and clears the file
    blk_start = 1; blk_load = 0; blk_list = 16'h0004; blk_ready = 0;
    applyStimulus();
    blk_start = 0; blk_list = 0;
    checkOutput("abort_busy_before", {31'b0, blk_busy}, 32'h1);
    rn_addr = 3; rm_addr = 1; rs_addr = 2;
    RESET = 1;
    #1;
    checkOutput("abort_busy", {31'b0, blk_busy}, 32'h0);
    checkOutput("abort_pc",   pc_out,  32'h0);
    checkOutput("abort_rn",   rn_data, 32'h0);
    checkOutput("abort_rm",   rm_data, 32'h0);
    checkOutput("abort_rs",   rs_data, 32'h0);
    applyStimulus();
    RESET = 0;
    checkOutput("abort_nodone", {31'b0, blk_done}, 32'h0);
    applyStimulus();
    checkOutput("abort_nodone2", {31'b0, blk_done}, 32'h0);
    checkOutput("abort_idle",    {31'b0, blk_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
